// File: rtl/keyscan_pkg.sv
// keyscan_pkg: shared constants, scan FSM states and the event record
// used by the matrix key scanner and its event FIFO.
package keyscan_pkg;

  localparam int KS_ROWS = 4;
  localparam int KS_COLS = 3;
  localparam int KS_KEYS = 12;

  typedef enum logic [2:0] {
    SETTLE,
    SAMPLE,
    EVAL0,
    EVAL1,
    EVAL2
  } ks_state_e;

  typedef struct packed {
    logic       press;
    logic [3:0] code;
  } ks_evt_t;

endpackage

// File: rtl/matrix_key_scanner_if.sv
// matrix_key_scanner_if: valid/ready event channel from the scanner
// (master) to the consuming control logic (slave).
interface matrix_key_scanner_if;

  logic       o_evt_valid;
  logic       i_evt_ready;
  logic [3:0] o_evt_code;
  logic       o_evt_press;

  modport master (
    output o_evt_valid,
    output o_evt_code,
    output o_evt_press,
    input  i_evt_ready
  );

  modport slave (
    input  o_evt_valid,
    input  o_evt_code,
    input  o_evt_press,
    output i_evt_ready
  );

endinterface

// File: rtl/keyscan_evt_fifo.sv
// keyscan_evt_fifo: 4-entry in-order event queue; a push into a full
// queue is only accepted when a pop frees a slot in the same cycle.
module keyscan_evt_fifo
  import keyscan_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    push,
  input  ks_evt_t push_evt,
  input  logic    pop,
  output ks_evt_t head,
  output logic    full,
  output logic    empty,
  output logic    drop
);

  ks_evt_t [3:0] mem_q, mem_d;
  logic [1:0]    wr_q, wr_d;
  logic [1:0]    rd_q, rd_d;
  logic [2:0]    cnt_q, cnt_d;
  logic          pop_ok;
  logic          push_ok;

  assign full    = (cnt_q == 3'd4);
  assign empty   = (cnt_q == 3'd0);
  assign head    = mem_q[rd_q];
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign drop    = push && !push_ok;

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (push_ok) begin
      mem_d[wr_q] = push_evt;
      wr_d        = wr_q + 2'd1;
    end
    if (pop_ok) begin
      rd_d = rd_q + 2'd1;
    end
    case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + 3'd1;
      2'b01:   cnt_d = cnt_q - 3'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/matrix_key_scanner.sv
// matrix_key_scanner: 4x3 key matrix scan, per-key debounce, event queue.
// Define KEYSCAN_SYNC_EN to add a 2-flop synchronizer on i_col.
module matrix_key_scanner
  import keyscan_pkg::*;
#(
  parameter int unsigned SCAN_DIV       = 8,
  parameter int unsigned DEBOUNCE_SCANS = 4
) (
  input  logic               aclk,
  input  logic               areset,
  output logic [KS_ROWS-1:0] o_row,
  input  logic [KS_COLS-1:0] i_col,
  output logic [KS_KEYS-1:0] o_key_state,
  output logic               o_overflow,
  matrix_key_scanner_if.master evt
);

  localparam logic [7:0] SETL_LAST = 8'(SCAN_DIV - 1);
  localparam logic [3:0] DB_LAST   = 4'(DEBOUNCE_SCANS - 1);

  ks_state_e                state_q, state_d;
  logic [1:0]               row_q, row_d;
  logic [7:0]               set_q, set_d;
  logic [KS_COLS-1:0]       raw_q, raw_d;
  logic [KS_KEYS-1:0]       stable_q, stable_d;
  logic [KS_KEYS-1:0][3:0]  cnt_q, cnt_d;
  logic [KS_ROWS-1:0]       o_row_q, o_row_d;
  logic                     ovf_q, ovf_d;
  logic [KS_COLS-1:0]       col_s;

  logic                     eval;
  logic [1:0]               col_sel;
  logic [3:0]               idx;
  logic                     push;
  ks_evt_t                  push_evt;
  ks_evt_t                  head;
  logic                     full;
  logic                     empty;
  logic                     drop;
  logic                     pop;

`ifdef KEYSCAN_SYNC_EN
  logic [KS_COLS-1:0] sync1_q;
  logic [KS_COLS-1:0] sync2_q;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= i_col;
      sync2_q <= sync1_q;
    end
  end

  assign col_s = sync2_q;
`else
  assign col_s = i_col;
`endif

  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    set_d    = set_q;
    raw_d    = raw_q;
    stable_d = stable_q;
    cnt_d    = cnt_q;
    eval     = 1'b0;
    col_sel  = 2'd0;
    push     = 1'b0;
    push_evt = '0;
    // Row drive lags the FSM row by one cycle, so each row is driven
    // for a full row period starting on the edge after it is selected.
    o_row_d  = ~(4'b0001 << row_q);
    ovf_d    = ovf_q | drop;
    case (state_q)
      SETTLE: begin
        if (set_q == SETL_LAST) begin
          set_d   = '0;
          state_d = SAMPLE;
        end else begin
          set_d = set_q + 8'd1;
        end
      end
      SAMPLE: begin
        raw_d   = ~col_s;
        state_d = EVAL0;
      end
      EVAL0: begin
        eval    = 1'b1;
        col_sel = 2'd0;
        state_d = EVAL1;
      end
      EVAL1: begin
        eval    = 1'b1;
        col_sel = 2'd1;
        state_d = EVAL2;
      end
      EVAL2: begin
        eval    = 1'b1;
        col_sel = 2'd2;
        row_d   = row_q + 2'd1;
        state_d = SETTLE;
      end
      default: state_d = SETTLE;
    endcase

    idx = {col_sel, row_q};
    if (eval) begin
      if (raw_q[col_sel] == stable_q[idx]) begin
        cnt_d[idx] = '0;
      end else if (cnt_q[idx] == DB_LAST) begin
        cnt_d[idx]     = '0;
        stable_d[idx]  = ~stable_q[idx];
        push           = 1'b1;
        push_evt.press = ~stable_q[idx];
        push_evt.code  = idx;
      end else begin
        cnt_d[idx] = cnt_q[idx] + 4'd1;
      end
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q  <= SETTLE;
      row_q    <= '0;
      set_q    <= '0;
      raw_q    <= '0;
      stable_q <= '0;
      cnt_q    <= '0;
      o_row_q  <= '1;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      row_q    <= row_d;
      set_q    <= set_d;
      raw_q    <= raw_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      o_row_q  <= o_row_d;
      ovf_q    <= ovf_d;
    end
  end

  assign pop = ~empty & evt.i_evt_ready;

  keyscan_evt_fifo u_fifo (
    .clk      (aclk),
    .rst      (areset),
    .push     (push),
    .push_evt (push_evt),
    .pop      (pop),
    .head     (head),
    .full     (full),
    .empty    (empty),
    .drop     (drop)
  );

  assign o_row           = o_row_q;
  assign o_key_state     = stable_q;
  assign o_overflow      = ovf_q;
  assign evt.o_evt_valid = ~empty;
  assign evt.o_evt_code  = head.code;
  assign evt.o_evt_press = head.press;

  logic unused_full;
  assign unused_full = full;

endmodule

// File: doc/matrix_key_scanner.md
# matrix_key_scanner

Scans a 4-row × 3-column push-button matrix on the board and reports debounced key state plus a queue of press/release events. It is the input-side counterpart of the colour-LED matrix driver: it drives rows one at a time and reads the columns back. Key index mapping matches the LED data word: index = col*4 + row. Events go to control logic over a valid/ready handshake.

## Interface
- SCAN_DIV, 8: settle cycles per row before sampling; legal range 3..255.
- DEBOUNCE_SCANS, 4: consecutive frames a raw key value must differ from stable state before it flips; legal range 1..15.
- aclk  in  1  system clock; all logic rising-edge.
- areset  in  1  asynchronous, active-high reset.
- o_row  out  4  row drive, active-low, at most one bit low.
- i_col  in  3  column sense, active-low (board pull-ups); asynchronous to aclk.
- o_key_state  out  12  debounced state, 1 = pressed, bit = col*4+row.
- o_evt_valid  out  1  event available.
- i_evt_ready  in  1  consumer accepts the event.
- o_evt_code  out  4  key index 0..11.
- o_evt_press  out  1  1 = press, 0 = release.
- o_overflow  out  1  sticky: an event was dropped.

## Operation
- Row FSM, repeated for row r = 0..3, then wraps to 0:
  - SETTLE: SCAN_DIV cycles with o_row[r] low.
  - SAMPLE: 1 cycle; latch ~col into raw[2:0].
  - EVAL0, EVAL1, EVAL2: 1 cycle each; evaluate key (c, r) for c = 0, 1, 2.
  - After EVAL2, r increments and the FSM returns to SETTLE.
- Per-key debounce, evaluated in EVALc:
  - If raw == stable: counter cleared.
  - Otherwise the counter increments. When it reaches DEBOUNCE_SCANS, stable flips, the counter clears, and one event {press = new stable, code = c*4+r} is pushed.
  - Counter width: 4 bits.
- Event FIFO, depth 4, in-order:
  - Push while full with no pop in the same cycle: the event is dropped, o_overflow is set, and o_key_state still updates.
  - Push and pop in the same cycle while full: both occur, nothing is dropped.
  - o_overflow clears only on reset.
- Handshake:
  - o_evt_code and o_evt_press stay stable while o_evt_valid && !i_evt_ready.
  - Transfer occurs when valid && ready.
  - o_evt_valid must not depend combinationally on i_evt_ready.

## Timing
- Row period = SCAN_DIV + 4 cycles. Frame = 4 × row period (48 cycles at defaults).
- Reset values:
  - o_row = 4'b1111 while areset is high.
  - o_key_state = 0, o_evt_valid = 0, o_overflow = 0, FIFO empty, all counters 0.
  - FSM in SETTLE with row 0 and settle count 0.
- After reset deasserts, o_row = 4'b1110 from the first clock edge.
- Reset asserted mid-operation: all state above clears immediately (asynchronously) and queued events are lost.
- Press-to-event latency: between DEBOUNCE_SCANS−1 and DEBOUNCE_SCANS frames, plus sync latency, after the level change.
- o_key_state bit and o_evt_valid (if the FIFO was empty) update on the same edge, one cycle after the deciding EVAL cycle.
- Several keys flipping in one row produce events in column order on consecutive cycles.

## Configuration
- KEYSCAN_SYNC_EN defined:
  - i_col passes through a 2-flop synchronizer before SAMPLE.
  - SCAN_DIV ≥ 3 guarantees the synchronized value reflects the current row.
- Not defined:
  - SAMPLE latches i_col directly, with no synchronizer.
  - Intended for synchronous sources and simulation only.

## Structure
- keyscan_pkg holds:
  - constants KS_ROWS = 4, KS_COLS = 3, KS_KEYS = 12;
  - FSM state enum (SETTLE, SAMPLE, EVAL0..EVAL2);
  - event struct {press, code[3:0]}.
- One sub-module, keyscan_evt_fifo: 4-entry FIFO with push/pop, full/empty and drop detection.

## Test plan
All scenarios use defaults (SCAN_DIV = 8, DEBOUNCE_SCANS = 4), i_col idle = 3'b111.
- Reset and scan pattern:
  - During reset: o_row = 1111 and all outputs are 0.
  - After release: o_row = 1110 for 12 cycles, then 1101, 1011, 0111, then 1110 again at cycle 48.
- Press key 6 (col1, row2):
  - Stimulus: hold i_col[1] low whenever o_row[2] is low.
  - Within 4 frames, o_key_state = 12'h040 and one event {code = 6, press = 1} is reported.
  - After release, and after 4 more frames, the event {6, 0} is reported and o_key_state = 0.
- Bounce rejection: key 6 is low for 3 frames, then high. o_key_state stays 0 and o_evt_valid never asserts.
- Simultaneous keys 0 and 4 (row0, col0 and col1):
  - Events {0, 1} then {4, 1} are queued on consecutive cycles.
  - o_key_state = 12'h011.
- Overflow and order:
  - Stimulus: i_evt_ready = 0; press keys 0, 1, 2, 3, 5 in turn.
  - First 4 events are retained, the 5th is dropped, and o_overflow = 1.
  - With ready = 1, the bench drains codes 0, 1, 2, 3 in order, and o_overflow stays 1.
- Reset mid-queue:
  - Stimulus: 2 events pending, then areset pulses.
  - o_evt_valid, o_key_state and o_overflow drop to 0 without waiting for a clock edge.
  - Scanning resumes at row 0.
